// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NAND = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_MUL  = 4'd9
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_sequential_if.sv
// Operand/result bus of the sequential ALU: valid/ready operand side plus
// registered result, flags, error and completion pulse.
interface alu_sequential_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   s;
    logic [N-1:0] z;
    logic         out_valid;
    logic [3:0]   flags;
    logic         err;

    modport master (
        output in_valid, a, b, s,
        input  in_ready, z, out_valid, flags, err
    );

    modport slave (
        input  in_valid, a, b, s,
        output in_ready, z, out_valid, flags, err
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier, one partial product per cycle.
// product/done present the final accumulator value combinationally during the
// last iteration so the caller can register it on the same edge.
module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [2*N-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_busy & (r_cnt == CW'(N - 1));
    assign product    = w_acc_next;

    // Load operands on start, then add/shift once per cycle until N steps are done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_sequential.sv
// Execute-stage ALU with registered result/NZCV flags, one-cycle ops accepted
// back-to-back and an N-cycle iterative MUL that blocks the input handshake.
module alu_sequential
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequential_if.slave  bus
);
    localparam int SHW = $clog2(N);

    alu_state_t       r_state;
    alu_state_t       w_state_next;

    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [2*N-1:0]   w_product;

    logic [SHW-1:0]   w_amt;
    logic [N:0]       w_add;
    logic [N:0]       w_sub;
    logic [N:0]       w_sll;
    logic [N:0]       w_srl;
    logic signed [N:0] w_sra;
    logic [N-1:0]     w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic [3:0]       w_flags;
    logic [3:0]       w_mul_flags;

    logic [N-1:0]     r_z;
    logic [3:0]       r_flags;
    logic             r_err;
    logic             r_out_valid;

    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.z         = r_z;
    assign bus.flags     = r_flags;
    assign bus.err       = r_err;
    assign bus.out_valid = r_out_valid;

    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_mul_start = w_accept & (bus.s == OP_MUL);

    shift_add_multiplier #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Shifts are done one bit wider so the last bit shifted out lands in the
    // extra bit; an amount of zero naturally leaves that bit at 0.
    assign w_amt = bus.b[SHW-1:0];
    assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_sll = {1'b0, bus.a} << w_amt;
    assign w_srl = {bus.a, 1'b0} >> w_amt;
    assign w_sra = $signed({bus.a, 1'b0}) >>> w_amt;

    // Single-cycle datapath: result, carry, overflow and illegal-opcode detect.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (bus.s)
            OP_ADD: begin
                w_res = w_add[N-1:0];
                w_c   = w_add[N];
                w_v   = (bus.a[N-1] == bus.b[N-1]) & (w_add[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                w_res = w_sub[N-1:0];
                w_c   = ~w_sub[N];
                w_v   = (bus.a[N-1] != bus.b[N-1]) & (w_sub[N-1] != bus.a[N-1]);
            end
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_NAND: w_res = ~(bus.a & bus.b);
            OP_SLL: begin
                w_res = w_sll[N-1:0];
                w_c   = w_sll[N];
            end
            OP_SRL: begin
                w_res = w_srl[N:1];
                w_c   = w_srl[0];
            end
            OP_SRA: begin
                w_res = w_sra[N:1];
                w_c   = w_sra[0];
            end
            OP_MUL:  w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    // Flag vectors for single-cycle results and for MUL completion.
    always_comb begin
        w_flags     = '0;
        w_mul_flags = '0;
        if (!w_err) begin
            w_flags[FLAG_N] = w_res[N-1];
            w_flags[FLAG_Z] = (w_res == '0);
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
        end
        w_mul_flags[FLAG_N] = w_product[N-1];
        w_mul_flags[FLAG_Z] = (w_product[N-1:0] == '0);
        w_mul_flags[FLAG_V] = |w_product[2*N-1:N];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: leave IDLE only for MUL, return when the multiplier finishes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_next = MUL;
            MUL:     if (w_mul_done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output registers: update on a completion, otherwise hold with out_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z         <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_z         <= w_product[N-1:0];
            r_flags     <= w_mul_flags;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_accept && !w_mul_start) begin
            r_z         <= w_res;
            r_flags     <= w_flags;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
